dds_seq_ctrl: RTL and testbench
===============================

// Module: dds_seq_ctrl
// PURPOSE
//  Sequencer for the DDS tone engine: soft-clears it, loads N tones (theta, delta, ampl) from a
//  valid/ready tone stream as single-cycle register-bus writes, then starts circulation.
//  Generates the sample strobe from a programmable divider. Sits between the AXI-lite regfile and dds.
// PARAMETERS
//  SIG_WIDTH  16  tone word width (theta/delta/ampl)
//  DIV_WIDTH  16  sample divider width
// PORTS
//  clk               in   1          clock
//  rst               in   1          synchronous reset, active-high
//  i_cmd_start       in   1          pulse: clear, load i_num_tones tones, run
//  i_cmd_resume      in   1          pulse: run the already-loaded table without reload
//  i_cmd_stop        in   1          pulse: stop circulation/abort load
//  i_num_tones       in   10         tone count; legal values 1,8,16,32,64,128,256,512
//  i_sample_div      in   DIV_WIDTH  sample period in clk cycles
//  i_tone_valid      in   1          tone word valid
//  o_tone_ready      out  1          tone word accepted when valid&ready
//  i_tone_theta      in   SIG_WIDTH  initial phase
//  i_tone_delta      in   SIG_WIDTH  phase increment
//  i_tone_ampl       in   SIG_WIDTH  amplitude (signed)
//  o_dds_ctrl_reg    out  32         bit0 soft reset, bit1 start; others 0
//  o_dds_addrs       out  32         0=THETAS 1=DELTAS 2=AMPLS
//  o_dds_write       out  1          write strobe
//  o_dds_thetas_reg  out  32         theta, zero-extended
//  o_dds_deltas_reg  out  32         delta, zero-extended
//  o_dds_ampls_reg   out  32         ampl, zero-extended
//  o_dds_lngth_reg   out  32         latched tone count
//  o_dds_sample_en   out  1          sample strobe, 1 cycle
//  o_busy            out  1          state != IDLE
//  o_loaded          out  1          table fully loaded since last clear
//  o_err             out  1          sticky command error
// BEHAVIOUR
//  - All outputs registered. Reset: state IDLE, all outputs 0, counters 0.
//  - FSM IDLE -> CLEAR -> LOAD -> RUN -> IDLE.
//  - IDLE:
//    - start with legal i_num_tones and i_sample_div >= i_num_tones+4: latch both, clear o_err,
//      go to CLEAR.
//    - start with illegal num_tones or too-small div: o_err=1, stay IDLE.
//    - resume with o_loaded=1 and latched div still valid: go to RUN. resume with o_loaded=0: o_err=1.
//    - stop in IDLE is ignored. stop with start/resume in the same cycle: stop wins (no action).
//  - CLEAR: exactly 1 cycle with ctrl bit0=1 and bit1=0; o_loaded<=0; tone counter<=0; next state LOAD.
//  - LOAD:
//    - o_tone_ready=1 only in the write sub-phase IDLE_W.
//    - On handshake: capture the tone into the bus regs. The next 3 cycles drive o_dds_write=1 with
//      addrs 0,1,2 in that order. ready=0 for those 3 cycles, so max rate is 1 tone per 4 cycles.
//    - After the 3rd write of tone i_num_tones: o_loaded<=1 and go to RUN.
//  - RUN:
//    - ctrl bit1=1, bit0=0; o_dds_write=0; o_tone_ready=0.
//    - Divider counter cleared on entry. o_dds_sample_en=1 when cnt==div-1, then cnt wraps to 0.
//    - First strobe is in the div-th RUN cycle.
//  - stop in CLEAR/LOAD/RUN: next cycle IDLE, ctrl=0, write=0, sample_en=0.
//    - An in-flight write triple is dropped. o_loaded is kept only if stop arrives in RUN.
//  - start/resume outside IDLE: ignored, no error.
//  - rst mid-operation: immediate return to reset values.
//  - o_dds_lngth_reg holds the latched count from start until the next accepted start.
// TESTING
//  - Reset then start(num=8, div=20), feed 8 tones back-to-back -> 1 CLEAR cycle (ctrl=1);
//    24 writes with addrs 0,1,2 repeating; then ctrl=2, lngth=8, o_loaded=1.
//  - RUN with div=20 -> sample_en pulses at RUN cycles 20, 40, 60; never 2 in a row.
//  - start(num=5) -> o_err=1, busy=0, no writes. start(num=8, div=10) (<12) -> o_err=1.
//    A legal start afterwards clears o_err.
//  - stop after the 3rd tone's THETAS write -> DELTAS/AMPLS writes absent; IDLE; o_loaded=0.
//    resume -> o_err=1.
//  - Full load num=1, RUN, stop, resume -> RUN with no CLEAR and no writes; ctrl=2; sample timer restarts.
//  - start+stop in the same cycle in IDLE -> stays IDLE, no error. rst asserted in LOAD ->
//    all outputs 0 next cycle.

Source files
------------

// File: rtl/dds_seq_ctrl.sv
// dds_seq_ctrl: soft-clears the DDS, loads a tone table as register-bus write triples,
// then runs circulation with a programmable sample strobe.
module dds_seq_ctrl #(
    parameter int SIG_WIDTH = 16,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_cmd_start,
    input  logic                 i_cmd_resume,
    input  logic                 i_cmd_stop,
    input  logic [9:0]           i_num_tones,
    input  logic [DIV_WIDTH-1:0] i_sample_div,
    input  logic                 i_tone_valid,
    output logic                 o_tone_ready,
    input  logic [SIG_WIDTH-1:0] i_tone_theta,
    input  logic [SIG_WIDTH-1:0] i_tone_delta,
    input  logic [SIG_WIDTH-1:0] i_tone_ampl,
    output logic [31:0]          o_dds_ctrl_reg,
    output logic [31:0]          o_dds_addrs,
    output logic                 o_dds_write,
    output logic [31:0]          o_dds_thetas_reg,
    output logic [31:0]          o_dds_deltas_reg,
    output logic [31:0]          o_dds_ampls_reg,
    output logic [31:0]          o_dds_lngth_reg,
    output logic                 o_dds_sample_en,
    output logic                 o_busy,
    output logic                 o_loaded,
    output logic                 o_err
);
    typedef enum logic [1:0] {IDLE, CLEAR, LOAD, RUN} state_t;
    state_t state, state_n;
    logic [1:0] sub, sub_n;
    logic [9:0] tcnt, tcnt_n;
    logic [DIV_WIDTH-1:0] div_q, cnt, cnt_n;
    logic loaded_n, err_n, cap, latch;
    logic num_ok, start_ok, resume_ok, writing_n;

    assign num_ok = i_num_tones == 10'd1 ||
                    (i_num_tones >= 10'd8 && (i_num_tones & (i_num_tones - 10'd1)) == 10'd0);
    assign start_ok = num_ok && 32'(i_sample_div) >= 32'(i_num_tones) + 32'd4;
    assign resume_ok = o_loaded && 32'(div_q) >= o_dds_lngth_reg + 32'd4;
    assign writing_n = state_n == LOAD && sub_n != 2'd0;

    // sub 0 waits for a tone; subs 1..3 emit the THETAS/DELTAS/AMPLS writes
    always_comb begin
        state_n  = state;
        sub_n    = sub;
        tcnt_n   = tcnt;
        cnt_n    = cnt;
        loaded_n = o_loaded;
        err_n    = o_err;
        cap      = 1'b0;
        latch    = 1'b0;
        case (state)
            IDLE: begin
                if (!i_cmd_stop && i_cmd_start) begin
                    if (start_ok) begin
                        latch   = 1'b1;
                        err_n   = 1'b0;
                        state_n = CLEAR;
                    end else begin
                        err_n = 1'b1;
                    end
                end else if (!i_cmd_stop && i_cmd_resume) begin
                    if (resume_ok) begin
                        state_n = RUN;
                        cnt_n   = '0;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            CLEAR: begin
                loaded_n = 1'b0;
                tcnt_n   = '0;
                sub_n    = '0;
                state_n  = LOAD;
            end
            LOAD: begin
                if (sub == 2'd0) begin
                    cap   = i_tone_valid && o_tone_ready;
                    sub_n = cap ? 2'd1 : 2'd0;
                end else if (sub == 2'd3) begin
                    sub_n  = 2'd0;
                    tcnt_n = tcnt + 10'd1;
                    if (tcnt + 10'd1 == o_dds_lngth_reg[9:0]) begin
                        state_n  = RUN;
                        loaded_n = 1'b1;
                        cnt_n    = '0;
                    end
                end else begin
                    sub_n = sub + 2'd1;
                end
            end
            default: cnt_n = (cnt == div_q - DIV_WIDTH'(1)) ? '0 : cnt + DIV_WIDTH'(1);
        endcase
        if (i_cmd_stop && state != IDLE) begin
            state_n  = IDLE;
            sub_n    = '0;
            cap      = 1'b0;
            loaded_n = state == RUN ? o_loaded : 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            sub              <= '0;
            tcnt             <= '0;
            cnt              <= '0;
            div_q            <= '0;
            o_loaded         <= 1'b0;
            o_err            <= 1'b0;
            o_tone_ready     <= 1'b0;
            o_dds_ctrl_reg   <= '0;
            o_dds_addrs      <= '0;
            o_dds_write      <= 1'b0;
            o_dds_thetas_reg <= '0;
            o_dds_deltas_reg <= '0;
            o_dds_ampls_reg  <= '0;
            o_dds_lngth_reg  <= '0;
            o_dds_sample_en  <= 1'b0;
            o_busy           <= 1'b0;
        end else begin
            state    <= state_n;
            sub      <= sub_n;
            tcnt     <= tcnt_n;
            cnt      <= cnt_n;
            o_loaded <= loaded_n;
            o_err    <= err_n;
            if (latch) begin
                div_q           <= i_sample_div;
                o_dds_lngth_reg <= 32'(i_num_tones);
            end
            if (cap) begin
                o_dds_thetas_reg <= 32'(i_tone_theta);
                o_dds_deltas_reg <= 32'(i_tone_delta);
                o_dds_ampls_reg  <= 32'(i_tone_ampl);
            end
            o_dds_ctrl_reg  <= state_n == CLEAR ? 32'd1 : state_n == RUN ? 32'd2 : 32'd0;
            o_dds_write     <= writing_n;
            o_dds_addrs     <= writing_n ? 32'(sub_n - 2'd1) : 32'd0;
            o_tone_ready    <= state_n == LOAD && sub_n == 2'd0;
            o_dds_sample_en <= state_n == RUN && cnt_n == div_q - DIV_WIDTH'(1);
            o_busy          <= state_n != IDLE;
        end
    end
endmodule

// File: tb/tb_dds_seq_ctrl.sv
// tb_dds_seq_ctrl: directed checks of the DDS sequencer load, run, stop, resume and error paths.
module tb_dds_seq_ctrl;
    logic clk = 0, rst = 1;
    logic start = 0, resume = 0, stop = 0, valid = 0;
    logic [9:0] num = 0;
    logic [15:0] div = 0, theta = 0, delta = 0, ampl = 0;
    logic ready, write, se, busy, loaded, err;
    logic [31:0] ctrl, addrs, thetas, deltas, ampls, lngth;
    int n_cmp = 0, n_bad = 0;
    int wr_n = 0, clr_n = 0, addr_bad = 0, dbl = 0;
    logic prev_wr = 0, prev_se = 0;
    logic [31:0] prev_addr = 0;
    int wr0, clr0;

    dds_seq_ctrl dut (
        .clk(clk), .rst(rst), .i_cmd_start(start), .i_cmd_resume(resume), .i_cmd_stop(stop),
        .i_num_tones(num), .i_sample_div(div), .i_tone_valid(valid), .o_tone_ready(ready),
        .i_tone_theta(theta), .i_tone_delta(delta), .i_tone_ampl(ampl),
        .o_dds_ctrl_reg(ctrl), .o_dds_addrs(addrs), .o_dds_write(write),
        .o_dds_thetas_reg(thetas), .o_dds_deltas_reg(deltas), .o_dds_ampls_reg(ampls),
        .o_dds_lngth_reg(lngth), .o_dds_sample_en(se), .o_busy(busy), .o_loaded(loaded),
        .o_err(err)
    );

    always #5 clk = ~clk;

    // write triples must run 0,1,2 with each triple starting at 0
    always @(negedge clk) begin
        if (write) begin
            if (addrs != (prev_wr ? prev_addr + 32'd1 : 32'd0)) addr_bad++;
            wr_n++;
        end
        if (ctrl == 32'd1) clr_n++;
        if (se && prev_se) dbl++;
        prev_wr = write;
        prev_addr = addrs;
        prev_se = se;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cmd_start(input logic [9:0] t, input logic [15:0] d);
        num = t;
        div = d;
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic pulse_stop();
        stop = 1;
        tick();
        stop = 0;
    endtask

    task automatic feed(input int n);
        for (int i = 0; i < n; i++) begin
            int k = 0;
            theta = 16'h1000 + 16'(i);
            delta = 16'h0100 + 16'(i);
            ampl = 16'h8000 | 16'(i);
            valid = 1;
            while (!ready && k < 20) begin
                tick();
                k++;
            end
            if (k >= 20) chk("ready_timeout", 32'(ready), 32'd1);
            tick();
        end
        valid = 0;
    endtask

    initial begin
        tick(2);
        rst = 0;
        chk("rst_ctrl", ctrl, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_flags", {29'd0, loaded, err, se}, 0);

        // full load of 8 tones, then run at div 20
        wr0 = wr_n;
        clr0 = clr_n;
        cmd_start(10'd8, 16'd20);
        chk("clear_ctrl", ctrl, 32'd1);
        chk("clear_busy", 32'(busy), 1);
        feed(8);
        chk("last_theta", thetas, 32'h0000_1007);
        chk("last_delta", deltas, 32'h0000_0107);
        chk("last_ampl", ampls, 32'h0000_8007);
        chk("wr_addr0", addrs, 0);
        tick(3);
        chk("run_ctrl", ctrl, 32'd2);
        chk("run_lngth", lngth, 32'd8);
        chk("run_loaded", 32'(loaded), 1);
        chk("run_write", 32'(write), 0);
        chk("load_writes", 32'(wr_n - wr0), 32'd24);
        chk("load_clears", 32'(clr_n - clr0), 32'd1);
        chk("addr_order", 32'(addr_bad), 0);
        tick(18);
        chk("se_c19", 32'(se), 0);
        tick();
        chk("se_c20", 32'(se), 1);
        tick();
        chk("se_c21", 32'(se), 0);
        tick(19);
        chk("se_c40", 32'(se), 1);
        tick(20);
        chk("se_c60", 32'(se), 1);
        pulse_stop();
        chk("stop_run_ctrl", ctrl, 0);
        chk("stop_run_busy", 32'(busy), 0);
        chk("stop_run_loaded", 32'(loaded), 1);

        // illegal starts, then a boundary-legal one
        wr0 = wr_n;
        cmd_start(10'd5, 16'd20);
        chk("bad_num_err", 32'(err), 1);
        chk("bad_num_busy", 32'(busy), 0);
        tick(3);
        chk("bad_num_nowr", 32'(wr_n - wr0), 0);
        cmd_start(10'd8, 16'd10);
        chk("bad_div_err", 32'(err), 1);
        chk("bad_div_busy", 32'(busy), 0);
        cmd_start(10'd8, 16'd12);
        chk("ok_start_err", 32'(err), 0);
        chk("ok_start_busy", 32'(busy), 1);
        pulse_stop();
        chk("stop_clr_loaded", 32'(loaded), 0);

        // abort after the 3rd tone's THETAS write
        wr0 = wr_n;
        cmd_start(10'd8, 16'd20);
        feed(3);
        chk("abort_pre_wr", 32'(write), 1);
        pulse_stop();
        chk("abort_write", 32'(write), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_loaded", 32'(loaded), 0);
        tick(4);
        chk("abort_writes", 32'(wr_n - wr0), 32'd7);
        resume = 1;
        tick();
        resume = 0;
        chk("resume_unloaded_err", 32'(err), 1);
        chk("resume_unloaded_busy", 32'(busy), 0);

        // single tone, run, stop, resume without reload
        cmd_start(10'd1, 16'd8);
        feed(1);
        tick(3);
        chk("n1_ctrl", ctrl, 32'd2);
        chk("n1_loaded", 32'(loaded), 1);
        tick(5);
        pulse_stop();
        wr0 = wr_n;
        clr0 = clr_n;
        resume = 1;
        tick();
        resume = 0;
        chk("resume_ctrl", ctrl, 32'd2);
        chk("resume_err", 32'(err), 0);
        tick(6);
        chk("resume_se_c7", 32'(se), 0);
        tick();
        chk("resume_se_c8", 32'(se), 1);
        chk("resume_nowr", 32'(wr_n - wr0), 0);
        chk("resume_noclr", 32'(clr_n - clr0), 0);
        pulse_stop();

        // start and stop together in IDLE
        stop = 1;
        cmd_start(10'd8, 16'd20);
        stop = 0;
        chk("startstop_busy", 32'(busy), 0);
        chk("startstop_err", 32'(err), 0);
        chk("startstop_ctrl", ctrl, 0);

        // reset in the middle of a load
        cmd_start(10'd8, 16'd20);
        feed(1);
        rst = 1;
        tick();
        rst = 0;
        chk("mid_rst_write", 32'(write), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_regs", ctrl | addrs | thetas | lngth | ampls, 0);
        chk("mid_rst_flags", {28'd0, ready, loaded, err, se}, 0);
        chk("no_double_se", 32'(dbl), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
